// File: rtl/mood_frame_streamer_pkg.sv
// Shared colour constants, mode encodings, FSM states and the mood palette.
package ili_pixel_pkg;

    localparam int unsigned RGB_W = 16;

    localparam logic [RGB_W-1:0] C_YELLOW = 16'hFFE0;
    localparam logic [RGB_W-1:0] C_CYAN   = 16'h07FF;
    localparam logic [RGB_W-1:0] C_RED    = 16'hF800;
    localparam logic [RGB_W-1:0] C_PURPLE = 16'h780F;
    localparam logic [RGB_W-1:0] C_BLUE   = 16'h001F;
    localparam logic [RGB_W-1:0] C_BLACK  = 16'h0000;
    localparam logic [RGB_W-1:0] C_WHITE  = 16'hFFFF;

    localparam logic [1:0] MODE_SOLID   = 2'd0;
    localparam logic [1:0] MODE_BORDER  = 2'd1;
    localparam logic [1:0] MODE_CHECKER = 2'd2;
    localparam logic [1:0] MODE_RSVD    = 2'd3;

    // Index that always selects the fallback palette entry.
    localparam int unsigned MOOD_INVALID = 255;

    typedef struct packed {
        logic [RGB_W-1:0] fg;
        logic [RGB_W-1:0] bg;
    } palette_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LATCH  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Foreground/background pair for a mood; unknown moods fall back to blue on black.
    function automatic palette_t mood_palette(input int unsigned idx);
        palette_t p;
        case (idx)
            32'd0:   p = '{fg: C_YELLOW, bg: C_BLACK};
            32'd1:   p = '{fg: C_CYAN,   bg: C_BLACK};
            32'd2:   p = '{fg: C_RED,    bg: C_WHITE};
            32'd3:   p = '{fg: C_PURPLE, bg: C_BLACK};
            32'd4:   p = '{fg: C_BLACK,  bg: C_WHITE};
            default: p = '{fg: C_BLUE,   bg: C_BLACK};
        endcase
        return p;
    endfunction

endpackage

// File: rtl/mood_frame_streamer_if.sv
// Pixel handshake bus between the frame source and the display controller.
interface mood_frame_streamer_if #(
    parameter int unsigned PIXEL_SIZE = 16
) ();

    logic                  pixel_valid;
    logic                  pixel_ready;
    logic [PIXEL_SIZE-1:0] pixel_data;
    logic                  pixel_first;
    logic                  pixel_last;

    modport master (
        output pixel_valid,
        output pixel_data,
        output pixel_first,
        output pixel_last,
        input  pixel_ready
    );

    modport slave (
        input  pixel_valid,
        input  pixel_data,
        input  pixel_first,
        input  pixel_last,
        output pixel_ready
    );

endinterface

// File: rtl/mood_frame_streamer_pattern_gen.sv
// Combinational pattern selector: picks fg or bg for a pixel coordinate.
module pattern_gen
    import ili_pixel_pkg::*;
#(
    parameter int unsigned H_RES      = 320,
    parameter int unsigned V_RES      = 240,
    parameter int unsigned PIXEL_SIZE = 16,
    parameter int unsigned BORDER_W   = 4,
    parameter int unsigned CHK_LOG2   = 3,
    localparam int unsigned XW        = (H_RES > 1) ? $clog2(H_RES) : 1,
    localparam int unsigned YW        = (V_RES > 1) ? $clog2(V_RES) : 1
) (
    input  logic [XW-1:0]         x_i,
    input  logic [YW-1:0]         y_i,
    input  logic [1:0]            mode_i,
    input  logic [PIXEL_SIZE-1:0] fg_i,
    input  logic [PIXEL_SIZE-1:0] bg_i,
    output logic [PIXEL_SIZE-1:0] pixel_o
);

    localparam logic [XW-1:0] X_LO = XW'(BORDER_W);
    localparam logic [XW-1:0] X_HI = XW'(H_RES - BORDER_W);
    localparam logic [YW-1:0] Y_LO = YW'(BORDER_W);
    localparam logic [YW-1:0] Y_HI = YW'(V_RES - BORDER_W);

    logic [XW-1:0] x_sh;
    logic [YW-1:0] y_sh;
    logic          on_border;
    logic          on_checker;

    // Checker square index bit is the coordinate bit at CHK_LOG2.
    assign x_sh       = x_i >> CHK_LOG2;
    assign y_sh       = y_i >> CHK_LOG2;
    assign on_checker = x_sh[0] ^ y_sh[0];
    assign on_border  = (x_i < X_LO) || (x_i >= X_HI) || (y_i < Y_LO) || (y_i >= Y_HI);

    // Reserved mode renders like SOLID.
    always_comb begin
        pixel_o = fg_i;
        case (mode_i)
            MODE_BORDER:  pixel_o = on_border  ? fg_i : bg_i;
            MODE_CHECKER: pixel_o = on_checker ? fg_i : bg_i;
            default:      pixel_o = fg_i;
        endcase
    end

endmodule

// File: rtl/mood_frame_streamer.sv
// Frame source for the ILI9341 controller: one pixel per handshake, mood/mode
// latched at frame start, first/last flags and a frame_done pulse.
module mood_frame_streamer
    import ili_pixel_pkg::*;
#(
    parameter int unsigned H_RES      = 320,
    parameter int unsigned V_RES      = 240,
    parameter int unsigned PIXEL_SIZE = 16,
    parameter int unsigned N_MOODS    = 5,
    parameter int unsigned BORDER_W   = 4,
    parameter int unsigned CHK_LOG2   = 3
) (
    input  logic                       clk_input_data,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [$clog2(N_MOODS)-1:0] mood_sel,
    input  logic [1:0]                 mode,
    mood_frame_streamer_if.master      pix,
    output logic                       frame_done,
    output logic [$clog2(N_MOODS)-1:0] active_mood
);

    localparam int unsigned MW = $clog2(N_MOODS);
    localparam int unsigned XW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int unsigned YW = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam logic [XW-1:0] X_MAX = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(V_RES - 1);

    state_e                state_q;
    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic [MW-1:0]         mood_q, mood_d;
    logic [1:0]            mode_q, mode_d;
    logic                  valid_q, first_q, last_q, done_q;
    logic [PIXEL_SIZE-1:0] data_q;

    logic                  hs_c;
    logic                  last_beat_c;
    logic                  first_c;
    logic                  last_c;
    palette_t              pal_c;
    logic [PIXEL_SIZE-1:0] fg_c, bg_c, pix_c;

    assign hs_c        = valid_q & pix.pixel_ready;
    assign last_beat_c = (x_q == X_MAX) && (y_q == Y_MAX);

    // Coordinate and frame settings that the next registered pixel will use.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        mood_d = mood_q;
        mode_d = mode_q;
        case (state_q)
            ST_LATCH: begin
                x_d    = '0;
                y_d    = '0;
                mood_d = mood_sel;
                mode_d = mode;
            end
            ST_STREAM: begin
                if (hs_c) begin
                    if (x_q == X_MAX) begin
                        x_d = '0;
                        y_d = (y_q == Y_MAX) ? '0 : y_q + YW'(1);
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Palette lookup for the upcoming pixel, out-of-range moods use the fallback entry.
    always_comb begin
        pal_c   = (32'(mood_d) < N_MOODS) ? mood_palette(32'(mood_d)) : mood_palette(MOOD_INVALID);
        fg_c    = PIXEL_SIZE'(pal_c.fg);
        bg_c    = PIXEL_SIZE'(pal_c.bg);
        first_c = (x_d == '0) && (y_d == '0);
        last_c  = (x_d == X_MAX) && (y_d == Y_MAX);
    end

    pattern_gen #(
        .H_RES      (H_RES),
        .V_RES      (V_RES),
        .PIXEL_SIZE (PIXEL_SIZE),
        .BORDER_W   (BORDER_W),
        .CHK_LOG2   (CHK_LOG2)
    ) u_pattern_gen (
        .x_i     (x_d),
        .y_i     (y_d),
        .mode_i  (mode_d),
        .fg_i    (fg_c),
        .bg_i    (bg_c),
        .pixel_o (pix_c)
    );

    // Frame FSM with registered pixel outputs; frames run to completion once latched.
    always_ff @(posedge clk_input_data) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            mood_q  <= '0;
            mode_q  <= MODE_SOLID;
            valid_q <= 1'b0;
            data_q  <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            x_q    <= x_d;
            y_q    <= y_d;
            mood_q <= mood_d;
            mode_q <= mode_d;
            case (state_q)
                ST_IDLE: begin
                    valid_q <= 1'b0;
                    if (enable) begin
                        state_q <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    state_q <= ST_STREAM;
                    valid_q <= 1'b1;
                    data_q  <= pix_c;
                    first_q <= first_c;
                    last_q  <= last_c;
                end
                ST_STREAM: begin
                    if (hs_c) begin
                        if (last_beat_c) begin
                            state_q <= ST_DONE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            data_q  <= '0;
                            first_q <= 1'b0;
                            last_q  <= 1'b0;
                        end else begin
                            data_q  <= pix_c;
                            first_q <= first_c;
                            last_q  <= last_c;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= enable ? ST_LATCH : ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pix.pixel_valid = valid_q;
    assign pix.pixel_data  = data_q;
    assign pix.pixel_first = first_q;
    assign pix.pixel_last  = last_q;
    assign frame_done      = done_q;
    assign active_mood     = mood_q;

endmodule

// File: tb/tb_mood_frame_streamer.sv
// Scoreboard bench for mood_frame_streamer on a small 8x4 frame.
module tb_mood_frame_streamer;

    localparam int TH = 8;
    localparam int TV = 4;
    localparam int NPIX = TH * TV;
    localparam int MAX_CYC = 400;

    typedef struct packed {
        logic [15:0] data;
        logic        first;
        logic        last;
    } beat_t;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [2:0] mood_sel;
    logic [1:0] mode;
    logic       frame_done;
    logic [2:0] active_mood;

    beat_t exp_q[$];
    beat_t got_q[$];
    int    n_tests;
    int    n_fail;

    mood_frame_streamer_if #(.PIXEL_SIZE(16)) pix_if ();

    mood_frame_streamer #(
        .H_RES(TH), .V_RES(TV), .PIXEL_SIZE(16), .N_MOODS(5), .BORDER_W(1), .CHK_LOG2(1)
    ) dut (
        .clk_input_data (clk),
        .rst            (rst),
        .enable         (enable),
        .mood_sel       (mood_sel),
        .mode           (mode),
        .pix            (pix_if.master),
        .frame_done     (frame_done),
        .active_mood    (active_mood)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model_pixel(input int mood, input int md, input int x, input int y);
        logic [15:0] fg;
        logic [15:0] bg;
        bit          on;
        case (mood)
            0:       begin fg = 16'hFFE0; bg = 16'h0000; end
            1:       begin fg = 16'h07FF; bg = 16'h0000; end
            2:       begin fg = 16'hF800; bg = 16'hFFFF; end
            3:       begin fg = 16'h780F; bg = 16'h0000; end
            4:       begin fg = 16'h0000; bg = 16'hFFFF; end
            default: begin fg = 16'h001F; bg = 16'h0000; end
        endcase
        case (md)
            1:       on = (x < 1) || (x >= TH - 1) || (y < 1) || (y >= TV - 1);
            2:       on = (((x >> 1) ^ (y >> 1)) & 1) == 1;
            default: on = 1'b1;
        endcase
        return on ? fg : bg;
    endfunction

    task automatic push_frame(input int mood, input int md);
        beat_t b;
        for (int y = 0; y < TV; y++) begin
            for (int x = 0; x < TH; x++) begin
                b.data  = model_pixel(mood, md, x, y);
                b.first = (x == 0) && (y == 0);
                b.last  = (x == TH - 1) && (y == TV - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic do_reset();
        rst                = 1'b0;
        enable             = 1'b0;
        mood_sel           = 3'd0;
        mode               = 2'd0;
        pix_if.pixel_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    // Waits (bounded) until pixel_valid is seen; lat counts negedges waited.
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            lat++;
            if (pix_if.pixel_valid) break;
        end
    endtask

    // Captures accepted beats until frame_done or the cycle budget runs out.
    task automatic collect_frame(input int ready_pct, input int change_at,
                                 output bit done_seen, output bit valid_at_done,
                                 output int stall_viol);
        bit    stalled;
        beat_t held;
        beat_t cur;
        done_seen     = 1'b0;
        valid_at_done = 1'b0;
        stall_viol    = 0;
        stalled       = 1'b0;
        held          = '0;
        for (int c = 0; c < MAX_CYC; c++) begin
            @(negedge clk);
            cur = '{data: pix_if.pixel_data, first: pix_if.pixel_first, last: pix_if.pixel_last};
            if (frame_done) begin
                done_seen     = 1'b1;
                valid_at_done = pix_if.pixel_valid;
                break;
            end
            if (stalled && (!pix_if.pixel_valid || cur != held)) stall_viol++;
            pix_if.pixel_ready = ($urandom_range(99) < ready_pct);
            if (pix_if.pixel_valid && pix_if.pixel_ready) begin
                got_q.push_back(cur);
                stalled = 1'b0;
                if (got_q.size() == change_at) begin
                    mood_sel = 3'd3;
                    enable   = 1'b0;
                end
            end else begin
                stalled = pix_if.pixel_valid;
                held    = cur;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({pix_if.pixel_valid, pix_if.pixel_data, pix_if.pixel_first, pix_if.pixel_last,
             frame_done, active_mood} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%b d=%h f=%b l=%b done=%b mood=%0d required all 0",
                     pix_if.pixel_valid, pix_if.pixel_data, pix_if.pixel_first, pix_if.pixel_last,
                     frame_done, active_mood);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (pix_if.pixel_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_valid got %b required 0", pix_if.pixel_valid);
        end
    endtask

    task automatic test_solid_back_to_back();
        int lat, gap, sv, idx;
        bit ds, vd;
        beat_t e, g;
        do_reset();
        mood_sel = 3'd2; mode = 2'd0; enable = 1'b1;
        wait_valid(lat);
        n_tests++;
        if (lat !== 2) begin n_fail++; $display("FAIL start_latency got %0d required 2", lat); end
        n_tests++;
        if (pix_if.pixel_first !== 1'b1 || active_mood !== 3'd2) begin
            n_fail++;
            $display("FAIL start_flags got first=%b mood=%0d required first=1 mood=2", pix_if.pixel_first, active_mood);
        end
        for (int f = 0; f < 2; f++) begin
            push_frame(2, 0);
            collect_frame(100, -1, ds, vd, sv);
            if (f == 1) enable = 1'b0;
            n_tests++;
            if (ds !== 1'b1 || vd !== 1'b0) begin
                n_fail++;
                $display("FAIL solid_frame_done frame %0d got done=%b valid=%b required done=1 valid=0", f, ds, vd);
            end
            idx = 0;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (got_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL solid_beat %0d got none required data=%h", idx, e.data);
                end else begin
                    g = got_q.pop_front();
                    if (g !== e) begin
                        n_fail++;
                        $display("FAIL solid_beat %0d got %h/%b/%b required %h/%b/%b", idx, g.data, g.first, g.last, e.data, e.first, e.last);
                    end
                end
                idx++;
            end
            got_q.delete();
            if (f == 0) begin
                pix_if.pixel_ready = 1'b0;
                gap = 1;
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    if (pix_if.pixel_valid) break;
                    gap++;
                end
                n_tests++;
                if (gap !== 2) begin n_fail++; $display("FAIL frame_gap got %0d required 2", gap); end
            end
        end
    endtask

    task automatic test_border();
        int lat, sv, idx;
        bit ds, vd;
        beat_t e, g;
        do_reset();
        mood_sel = 3'd0; mode = 2'd1; enable = 1'b1;
        wait_valid(lat);
        enable = 1'b0;
        push_frame(0, 1);
        collect_frame(100, -1, ds, vd, sv);
        n_tests++;
        if (got_q.size() !== NPIX || got_q[9].data !== 16'h0000 || got_q[15].data !== 16'hFFE0) begin
            n_fail++;
            $display("FAIL border_points got n=%0d (1,1)=%h (7,1)=%h required 32 0000 FFE0", got_q.size(), got_q[9].data, got_q[15].data);
        end
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (got_q.size() == 0) begin
                n_fail++;
                $display("FAIL border_beat %0d got none required data=%h", idx, e.data);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL border_beat %0d got %h/%b/%b required %h/%b/%b", idx, g.data, g.first, g.last, e.data, e.first, e.last);
                end
            end
            idx++;
        end
        got_q.delete();
    endtask

    task automatic test_checker();
        int lat, sv, idx;
        bit ds, vd;
        beat_t e, g;
        do_reset();
        mood_sel = 3'd4; mode = 2'd2; enable = 1'b1;
        wait_valid(lat);
        enable = 1'b0;
        push_frame(4, 2);
        collect_frame(100, -1, ds, vd, sv);
        n_tests++;
        if (got_q.size() !== NPIX || got_q[0].data !== 16'hFFFF || got_q[2].data !== 16'h0000 || got_q[18].data !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL checker_points got n=%0d %h %h %h required 32 FFFF 0000 FFFF", got_q.size(), got_q[0].data, got_q[2].data, got_q[18].data);
        end
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (got_q.size() == 0) begin
                n_fail++;
                $display("FAIL checker_beat %0d got none required data=%h", idx, e.data);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL checker_beat %0d got %h required %h", idx, g.data, e.data);
                end
            end
            idx++;
        end
        got_q.delete();
    endtask

    task automatic test_backpressure();
        int lat, sv, idx;
        bit ds, vd;
        beat_t e, g;
        do_reset();
        mood_sel = 3'd3; mode = 2'd2; enable = 1'b1;
        wait_valid(lat);
        enable = 1'b0;
        push_frame(3, 2);
        collect_frame(50, -1, ds, vd, sv);
        n_tests++;
        if (got_q.size() !== NPIX || ds !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_handshakes got %0d done=%b required 32 done=1", got_q.size(), ds);
        end
        n_tests++;
        if (sv !== 0) begin n_fail++; $display("FAIL bp_stall_stable got %0d changes required 0", sv); end
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (got_q.size() == 0) begin
                n_fail++;
                $display("FAIL bp_beat %0d got none required data=%h", idx, e.data);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL bp_beat %0d got %h/%b/%b required %h/%b/%b", idx, g.data, g.first, g.last, e.data, e.first, e.last);
                end
            end
            idx++;
        end
        got_q.delete();
    endtask

    task automatic test_mid_frame_change();
        int lat, sv, idx, vcnt;
        bit ds, vd;
        beat_t e, g;
        do_reset();
        mood_sel = 3'd1; mode = 2'd0; enable = 1'b1;
        wait_valid(lat);
        push_frame(1, 0);
        collect_frame(100, 10, ds, vd, sv);
        n_tests++;
        if (ds !== 1'b1 || active_mood !== 3'd1) begin
            n_fail++;
            $display("FAIL mid_done got done=%b mood=%0d required done=1 mood=1", ds, active_mood);
        end
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (got_q.size() == 0) begin
                n_fail++;
                $display("FAIL mid_beat %0d got none required data=%h", idx, e.data);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL mid_beat %0d got %h required %h", idx, g.data, e.data);
                end
            end
            idx++;
        end
        got_q.delete();
        vcnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (pix_if.pixel_valid || frame_done) vcnt++;
        end
        n_tests++;
        if (vcnt !== 0) begin n_fail++; $display("FAIL mid_return_idle got %0d active cycles required 0", vcnt); end
    endtask

    task automatic test_out_of_range_mood();
        int lat, sv, idx;
        bit ds, vd;
        beat_t e, g;
        do_reset();
        mood_sel = 3'd6; mode = 2'd0; enable = 1'b1;
        wait_valid(lat);
        enable = 1'b0;
        n_tests++;
        if (active_mood !== 3'd6) begin n_fail++; $display("FAIL oor_active_mood got %0d required 6", active_mood); end
        push_frame(6, 0);
        collect_frame(100, -1, ds, vd, sv);
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (got_q.size() == 0) begin
                n_fail++;
                $display("FAIL oor_beat %0d got none required data=%h", idx, e.data);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL oor_beat %0d got %h required %h", idx, g.data, e.data);
                end
            end
            idx++;
        end
        got_q.delete();
    endtask

    task automatic test_reset_mid_frame();
        int lat, cnt, dcnt;
        bit hit;
        do_reset();
        mood_sel = 3'd2; mode = 2'd1; enable = 1'b1;
        wait_valid(lat);
        pix_if.pixel_ready = 1'b1;
        cnt = 0;
        hit = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (pix_if.pixel_valid) cnt++;
            if (cnt == 6) begin
                rst    = 1'b0;
                enable = 1'b0;
                hit    = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        n_tests++;
        if (!hit || {pix_if.pixel_valid, pix_if.pixel_data, pix_if.pixel_first, pix_if.pixel_last,
                     frame_done, active_mood} !== 23'd0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs hit=%b got v=%b d=%h f=%b l=%b done=%b mood=%0d required all 0",
                     hit, pix_if.pixel_valid, pix_if.pixel_data, pix_if.pixel_first, pix_if.pixel_last,
                     frame_done, active_mood);
        end
        @(negedge clk);
        rst  = 1'b1;
        dcnt = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (frame_done || pix_if.pixel_valid) dcnt++;
        end
        n_tests++;
        if (dcnt !== 0) begin n_fail++; $display("FAIL rst_mid_no_done got %0d active cycles required 0", dcnt); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_solid_back_to_back();
        test_border();
        test_checker();
        test_backpressure();
        test_mid_frame_change();
        test_out_of_range_mood();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
